ad2s1210_scheduler: RTL and testbench

- Sequencer and arbiter for one AD2S1210 resolver interface.
- Generates periodic position/velocity read requests, a fault-register check every N samples, and host-triggered configuration writes.
- Grants the shared SPI stream and the SAMPLE/A0-A1 pin mux to exactly one engine at a time: position reader, fault handler, or config writer.
- Sits between the control-bus register file and the three engines. Drives their start pulses and the downstream pin/stream mux select.

---
 rtl/ad2s1210_pkg.sv | 34 +++
 rtl/ad2s1210_sample_timer.sv | 53 +++++
 rtl/ad2s1210_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_ad2s1210_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad2s1210_pkg.sv
// Shared types and constants for the AD2S1210 resolver scheduler.
// The optional watchdog is enabled with `define AD2S1210_WATCHDOG_EN.
package ad2s1210_pkg;

  localparam int unsigned PERIOD_W = 32;
  localparam int unsigned FDIV_W   = 8;

  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2);

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_POS   = 2'd1,
    GRANT_FAULT = 2'd2,
    GRANT_CFG   = 2'd3
  } grant_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic pos;
    logic fault;
    logic cfg;
  } pend_t;

  // Periods below the minimum would make the tick condition unreachable.
  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

endpackage

// File: rtl/ad2s1210_sample_timer.sv
// Sample-period counter and fault-check divider for the AD2S1210 scheduler.
// Part of the scheduler built with optional `define AD2S1210_WATCHDOG_EN.
module ad2s1210_sample_timer
  import ad2s1210_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] sample_period,
  input  logic [FDIV_W-1:0]   fault_divider,
  output logic                tick,
  output logic                fault_tick
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] period_q;
  logic [FDIV_W-1:0]   div_cnt;

  // period_q is resampled only while count sits at 0, so a new period lands at the wrap
  assign tick = enable && (count != '0) && (count == period_q - PERIOD_W'(1));

  assign fault_tick = tick && (fault_divider != '0) &&
                      (div_cnt >= fault_divider - FDIV_W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      period_q <= MIN_PERIOD;
    end else begin
      if (count == '0) begin
        period_q <= clamp_period(sample_period);
      end
      if (!enable || tick) begin
        count <= '0;
      end else begin
        count <= count + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (fault_divider == '0) begin
      div_cnt <= '0;
    end else if (fault_tick) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= div_cnt + FDIV_W'(1);
    end
  end

endmodule

// File: rtl/ad2s1210_scheduler.sv
// Request sequencer and single-owner arbiter for one AD2S1210 resolver interface.
// Define AD2S1210_WATCHDOG_EN to abort engines that stay granted for TIMEOUT clocks.
module ad2s1210_scheduler
  import ad2s1210_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned OVR_W   = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] sample_period,
  input  logic [FDIV_W-1:0]   fault_divider,
  input  logic                cfg_req,
  output logic                cfg_ack,
  output logic                pos_start,
  input  logic                pos_done,
  output logic                fault_start,
  input  logic                fault_done,
  output logic                cfg_start,
  input  logic                cfg_done,
  output logic [1:0]          grant,
  output logic                busy,
  output logic [OVR_W-1:0]    overrun_count,
  output logic                timeout_error
);

  sched_state_t state, state_nxt;
  grant_t       grant_q, grant_nxt, pick_c;
  pend_t        pend, clr_c;

  logic tick, fault_tick;
  logic done_c, abort_c, cfg_busy_c;
  logic pos_start_nxt, fault_start_nxt, cfg_start_nxt, cfg_ack_nxt;

  ad2s1210_sample_timer u_timer (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .sample_period (sample_period),
    .fault_divider (fault_divider),
    .tick          (tick),
    .fault_tick    (fault_tick)
  );

  // Fixed priority: position > fault > config
  always_comb begin
    pick_c = GRANT_NONE;
    if (pend.pos) begin
      pick_c = GRANT_POS;
    end else if (pend.fault) begin
      pick_c = GRANT_FAULT;
    end else if (pend.cfg) begin
      pick_c = GRANT_CFG;
    end
  end

  // Only the granted engine's done is honoured
  always_comb begin
    done_c = 1'b0;
    case (grant_q)
      GRANT_POS:   done_c = pos_done;
      GRANT_FAULT: done_c = fault_done;
      GRANT_CFG:   done_c = cfg_done;
      default:     done_c = 1'b0;
    endcase
  end

`ifdef AD2S1210_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign abort_c = (state == ST_RUN) && !done_c && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_START) begin
        wd_cnt <= '0;
      end else if (state == ST_RUN) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (abort_c) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_error = timeout_q;
`else
  assign abort_c       = 1'b0;
  assign timeout_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (enable && (pick_c != GRANT_NONE)) state_nxt = ST_START;
      ST_START: state_nxt = ST_RUN;
      ST_RUN:   if (done_c || abort_c) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; starts land in the START cycle
  always_comb begin
    grant_nxt       = grant_q;
    pos_start_nxt   = 1'b0;
    fault_start_nxt = 1'b0;
    cfg_start_nxt   = 1'b0;
    cfg_ack_nxt     = 1'b0;
    clr_c           = '0;
    case (state)
      ST_IDLE: begin
        grant_nxt = GRANT_NONE;
        if (enable) begin
          grant_nxt = pick_c;
          case (pick_c)
            GRANT_POS:   begin pos_start_nxt   = 1'b1; clr_c.pos   = 1'b1; end
            GRANT_FAULT: begin fault_start_nxt = 1'b1; clr_c.fault = 1'b1; end
            GRANT_CFG:   begin cfg_start_nxt   = 1'b1; clr_c.cfg   = 1'b1; end
            default:     ;
          endcase
        end
      end
      ST_RUN: begin
        if (done_c) begin
          grant_nxt   = GRANT_NONE;
          cfg_ack_nxt = (grant_q == GRANT_CFG);
        end else if (abort_c) begin
          grant_nxt = GRANT_NONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_q     <= GRANT_NONE;
      busy        <= 1'b0;
      pos_start   <= 1'b0;
      fault_start <= 1'b0;
      cfg_start   <= 1'b0;
      cfg_ack     <= 1'b0;
    end else begin
      grant_q     <= grant_nxt;
      busy        <= (grant_nxt != GRANT_NONE);
      pos_start   <= pos_start_nxt;
      fault_start <= fault_start_nxt;
      cfg_start   <= cfg_start_nxt;
      cfg_ack     <= cfg_ack_nxt;
    end
  end

  assign grant = grant_q;

  // A config op is in flight from the cycle it is picked until its grant drops
  assign cfg_busy_c = (grant_q == GRANT_CFG) || clr_c.cfg;

  // Pending flags: set wins over clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend          <= '0;
      overrun_count <= '0;
    end else begin
      pend.pos   <= tick | (pend.pos & ~clr_c.pos);
      pend.fault <= fault_tick | (pend.fault & ~clr_c.fault);
      pend.cfg   <= (cfg_req & ~cfg_busy_c) | (pend.cfg & ~clr_c.cfg);
      if (tick && pend.pos && (overrun_count != '1)) begin
        overrun_count <= overrun_count + OVR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ad2s1210_scheduler.sv
// Directed bench for ad2s1210_scheduler; checks both builds of AD2S1210_WATCHDOG_EN.
module tb_ad2s1210_scheduler;
  import ad2s1210_pkg::*;

  localparam int unsigned TB_OVR_W   = 6;
  localparam int unsigned TB_TIMEOUT = 64;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                enable = 1'b0;
  logic [31:0]         sample_period = 32'd0;
  logic [7:0]          fault_divider = 8'd0;
  logic                cfg_req = 1'b0;
  logic                cfg_ack;
  logic                pos_start, fault_start, cfg_start;
  logic                pos_done = 1'b0, fault_done = 1'b0, cfg_done = 1'b0;
  logic [1:0]          grant;
  logic                busy;
  logic [TB_OVR_W-1:0] overrun_count;
  logic                timeout_error;

  ad2s1210_scheduler #(.TIMEOUT(TB_TIMEOUT), .OVR_W(TB_OVR_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .sample_period (sample_period),
    .fault_divider (fault_divider),
    .cfg_req       (cfg_req),
    .cfg_ack       (cfg_ack),
    .pos_start     (pos_start),
    .pos_done      (pos_done),
    .fault_start   (fault_start),
    .fault_done    (fault_done),
    .cfg_start     (cfg_start),
    .cfg_done      (cfg_done),
    .grant         (grant),
    .busy          (busy),
    .overrun_count (overrun_count),
    .timeout_error (timeout_error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int nfault = 0;
  int pos_delay = 0, fault_delay = 0, cfg_delay = 0;
  int pos_cnt = 0, fault_cnt = 0, cfg_cnt = 0;

  // cyc = k during the k-th clock after reset release
  always @(posedge clock) cyc <= reset ? cyc + 1 : 0;

  always @(negedge clock) begin
    if (!reset) nfault <= 0;
    else if (fault_start) nfault <= nfault + 1;
  end

  // Engine models: done pulses <delay> cycles after the start cycle; delay 0 = never
  initial begin
    forever begin
      @(negedge clock);
      pos_done = 1'b0; fault_done = 1'b0; cfg_done = 1'b0;
      if (!reset) begin
        pos_cnt = 0; fault_cnt = 0; cfg_cnt = 0;
      end else begin
        if (pos_cnt != 0)   begin pos_cnt--;   if (pos_cnt == 0)   pos_done = 1'b1;   end
        if (fault_cnt != 0) begin fault_cnt--; if (fault_cnt == 0) fault_done = 1'b1; end
        if (cfg_cnt != 0)   begin cfg_cnt--;   if (cfg_cnt == 0)   cfg_done = 1'b1;   end
        if (pos_start)   pos_cnt = pos_delay;
        if (fault_start) fault_cnt = fault_delay;
        if (cfg_start)   cfg_cnt = cfg_delay;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return pos_start;
      1:       return fault_start;
      2:       return cfg_start;
      default: return cfg_ack;
    endcase
  endfunction

  // Returns the cycle in which the selected output is seen high, or -1 on budget expiry
  task automatic wait_sig(input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clock);
      if (sig_of(which)) at = cyc;
    end
  endtask

  task automatic do_reset(input logic [31:0] per, input logic [7:0] fd,
                          input int pd, input int fdl, input int cd);
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b1;
    cfg_req = 1'b0;
    sample_period = per;
    fault_divider = fd;
    pos_delay = pd; fault_delay = fdl; cfg_delay = cd;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [31:0] per;
    logic [7:0]  fd;
    int          pd;
    int          fdl;
    int          nst;
    int          exp_first;
    int          exp_int;
    int          exp_glen;
    int          exp_faults;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs[NV];

  initial begin
    #500000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int at, prev, glen, fc;

    // Tick at count P-1, pending the next cycle, start pulse the cycle after that
    vecs[0] = '{32'd100, 8'd0, 10, 10, 3, 101, 100, 11, 0};
    vecs[1] = '{32'd100, 8'd4, 10, 10, 9, 101, 100, 11, 2};
    vecs[2] = '{32'd7,   8'd1,  1,  2, 5,   8,   7,  2, 4};
    vecs[3] = '{32'd3,   8'd0,  1,  1, 6,   4,   3,  2, 0};
    vecs[4] = '{32'd50,  8'd2,  5,  5, 5,  51,  50,  6, 2};

    repeat (2) @(negedge clock);
    check("reset_outputs",
          {grant, busy, pos_start, fault_start, cfg_start, cfg_ack, overrun_count, timeout_error},
          '0);

    for (int v = 0; v < NV; v++) begin
      do_reset(vecs[v].per, vecs[v].fd, vecs[v].pd, vecs[v].fdl, 1);
      wait_sig(0, 400, at);
      check("first_start", 64'(at), 64'(vecs[v].exp_first));
      prev = at;
      fc = 0;
      for (int k = 1; k <= vecs[v].nst; k++) begin
        if (k > 1) begin
          wait_sig(0, 400, at);
          check("start_interval", 64'(at - prev), 64'(vecs[v].exp_int));
          prev = at;
        end
        if (k == vecs[v].nst) fc = nfault;
        glen = 0;
        while (grant == 2'(GRANT_POS) && glen < 1000) begin
          glen++;
          @(negedge clock);
        end
        if (k == 1) check("grant_len", 64'(glen), 64'(vecs[v].exp_glen));
        if (vecs[v].fd != 8'd0 && k == int'(vecs[v].fd)) begin
          check("gap_before_fault", 64'(grant), 64'(0));
          @(negedge clock);
          check("fault_after_gap", {fault_start, grant}, {1'b1, 2'd2});
        end
      end
      check("fault_count", 64'(fc), 64'(vecs[v].exp_faults));
      check("overrun_zero", 64'(overrun_count), 64'(0));
    end

    // enable low holds the timer; first tick counts from the cycle enable rises
    do_reset(32'd10, 8'd0, 1, 1, 1);
    enable = 1'b0;
    wait_sig(0, 60, at);
    check("disabled_no_start", 64'(at), 64'(-1));
    enable = 1'b1;
    wait_sig(0, 100, at);
    check("enable_first_start", 64'(at), 64'(71));

    // cfg raised in the tick cycle: pos first, one idle cycle, then cfg
    do_reset(32'd40, 8'd0, 5, 1, 4);
    repeat (39) @(negedge clock);
    cfg_req = 1'b1;
    wait_sig(0, 100, at);
    check("prio_pos_start", 64'(at), 64'(41));
    wait_sig(2, 100, at);
    check("prio_cfg_start", 64'(at), 64'(48));
    check("cfg_grant", {busy, grant}, {1'b1, 2'd3});
    cfg_req = 1'b0;
    wait_sig(3, 100, at);
    check("cfg_ack_cycle", 64'(at), 64'(53));
    check("cfg_ack_grant", {busy, grant}, 3'd0);
    @(negedge clock);
    check("cfg_ack_width", 64'(cfg_ack), 64'(0));

    // Position engine stalled: ticks at 39 (pend), 59 and 79 (overruns)
    do_reset(32'd20, 8'd0, 65, 1, 1);
    wait_sig(0, 100, at);
    check("stall_first_start", 64'(at), 64'(21));
    repeat (49) @(negedge clock);
    check("overrun_1", 64'(overrun_count), 64'(1));
    repeat (16) @(negedge clock);
    check("overrun_2", 64'(overrun_count), 64'(2));

    // Period 0 runs at 2: overrun k-1 visible at cycle 2k+2, then saturation
    do_reset(32'd0, 8'd0, 0, 1, 1);
    repeat (20) @(negedge clock);
    check("min_period_ovr20", 64'(overrun_count), 64'(8));
    repeat (40) @(negedge clock);
    check("min_period_ovr60", 64'(overrun_count), 64'(28));
    repeat (240) @(negedge clock);
    check("overrun_saturate", 64'(overrun_count), 64'({TB_OVR_W{1'b1}}));

    // Asynchronous reset while cfg owns the bus
    do_reset(32'd1000, 8'd0, 1, 1, 0);
    cfg_req = 1'b1;
    wait_sig(2, 50, at);
    check("rst_cfg_start", 64'(at), 64'(2));
    cfg_req = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_pre_grant", 64'(grant), 64'(3));
    #2 reset = 1'b0;
    #1 check("async_reset_clear", {grant, busy, pos_start, fault_start, cfg_start}, '0);
    @(negedge clock);
    sample_period = 32'd10;
    @(negedge clock);
    reset = 1'b1;
    wait_sig(0, 100, at);
    check("post_reset_start", 64'(at), 64'(11));

    // Fault engine never answers
    do_reset(32'd100, 8'd1, 5, 0, 1);
    wait_sig(1, 200, at);
    check("wd_fault_start", 64'(at), 64'(108));
`ifdef AD2S1210_WATCHDOG_EN
    at = -1;
    for (int i = 0; i < 200 && at < 0; i++) begin
      @(negedge clock);
      if (grant != 2'(GRANT_FAULT)) at = cyc;
    end
    check("wd_abort_cycle", 64'(at), 64'(173));
    check("wd_abort_state", {timeout_error, grant}, {1'b1, 2'd0});
    wait_sig(0, 100, at);
    check("wd_next_tick", 64'(at), 64'(201));
    check("wd_sticky", 64'(timeout_error), 64'(1));
`else
    repeat (120) @(negedge clock);
    check("no_wd_hold", {timeout_error, grant}, {1'b0, 2'd2});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
